// File: rtl/unix_time_counter_if.sv
// Control/status bundle between the seconds counter and its host logic.
// The master drives load/run/alarm controls; the slave returns time and flags.
interface unix_time_counter_if #(
  parameter int N = 64,
  parameter int M = 26
);
  logic         load_n;
  logic         go;
  logic [N-1:0] set_counter;
  logic         alarm_we;
  logic [N-1:0] alarm_set;
  logic         alarm_en;
  logic         alarm_ack;
  logic [N-1:0] counter;
  logic [M-1:0] sub_count;
  logic         tick;
  logic         alarm_hit;
  logic         alarm_pending;
  logic         wrapped;

  modport master (
    output load_n, go, set_counter, alarm_we, alarm_set, alarm_en, alarm_ack,
    input  counter, sub_count, tick, alarm_hit, alarm_pending, wrapped
  );

  modport slave (
    input  load_n, go, set_counter, alarm_we, alarm_set, alarm_en, alarm_ack,
    output counter, sub_count, tick, alarm_hit, alarm_pending, wrapped
  );
endinterface

// File: rtl/unix_time_counter.sv
// Unix-epoch seconds counter driven by a DIV-cycle prescaler strobe, with
// synchronous load, pause, alarm compare (sticky pending) and wrap flag.
module unix_time_counter #(
  parameter int N   = 64,
  parameter int DIV = 50_000_000,
  parameter int M   = 26
) (
  input logic               clk,
  input logic               reset,
  unix_time_counter_if.slave bus
);
  localparam logic [M-1:0] TERM = M'(DIV - 1);

  logic [N-1:0] counter_q, counter_d;
  logic [M-1:0] sub_q, sub_d;
  logic [N-1:0] alarm_q, alarm_d;
  logic         tick_q, tick_d;
  logic         hit_q, hit_d;
  logic         pend_q, pend_d;
  logic         wrap_q, wrap_d;
  logic [N-1:0] cnt_inc;

  assign cnt_inc = counter_q + N'(1);

  always_comb begin
    counter_d = counter_q;
    sub_d     = sub_q;
    alarm_d   = bus.alarm_we ? bus.alarm_set : alarm_q;
    tick_d    = 1'b0;
    hit_d     = 1'b0;
    pend_d    = pend_q & ~bus.alarm_ack;
    wrap_d    = wrap_q;
    if (!bus.load_n) begin
      counter_d = bus.set_counter;
      sub_d     = '0;
      wrap_d    = 1'b0;
    end else if (bus.go) begin
      if (sub_q == TERM) begin
        sub_d     = '0;
        counter_d = cnt_inc;
        tick_d    = 1'b1;
        if (&counter_q) wrap_d = 1'b1;
        // Compare against the alarm value held before this edge.
        if (bus.alarm_en && cnt_inc == alarm_q) begin
          hit_d  = 1'b1;
          pend_d = 1'b1;
        end
      end else begin
        sub_d = sub_q + M'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter_q <= '0;
      sub_q     <= '0;
      alarm_q   <= '0;
      tick_q    <= 1'b0;
      hit_q     <= 1'b0;
      pend_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      counter_q <= counter_d;
      sub_q     <= sub_d;
      alarm_q   <= alarm_d;
      tick_q    <= tick_d;
      hit_q     <= hit_d;
      pend_q    <= pend_d;
      wrap_q    <= wrap_d;
    end
  end

  assign bus.counter       = counter_q;
  assign bus.sub_count     = sub_q;
  assign bus.tick          = tick_q;
  assign bus.alarm_hit     = hit_q;
  assign bus.alarm_pending = pend_q;
  assign bus.wrapped       = wrap_q;
endmodule
